// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external bus controller: FSM state encoding,
// default chip-select window and the fixed-priority one-hot selector.
package ext_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } ext_bus_state_t;

    // Default inclusive chip-select window (cartridge space).
    localparam logic [15:0] CS_BASE_DFLT  = 16'hA000;
    localparam logic [15:0] CS_LIMIT_DFLT = 16'hFDFF;

    // Widest requester vector the selector handles; callers zero-extend.
    localparam int ARB_MAX_CH = 32;

    // Isolate the lowest set bit: index 0 has the highest priority.
    function automatic logic [ARB_MAX_CH-1:0] prio_onehot(input logic [ARB_MAX_CH-1:0] r);
        return r & (~r + ARB_MAX_CH'(1));
    endfunction

endpackage

// File: rtl/ext_bus_ctrl_prio_arb.sv
// Combinational fixed-priority arbiter; the parent registers the winner.
module prio_arb
    import ext_bus_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0] req,
    input  logic           en,
    output logic [NCH-1:0] gnt
);

    logic [ARB_MAX_CH-1:0] req_w;
    logic [ARB_MAX_CH-1:0] sel_w;

    assign req_w = ARB_MAX_CH'(req);
    assign sel_w = prio_onehot(req_w);
    assign gnt   = en ? sel_w[NCH-1:0] : '0;

    // Upper selector bits are always zero for a zero-extended request.
    generate
        if (NCH < ARB_MAX_CH) begin : g_pad
            logic unused_hi;
            assign unused_hi = |sel_w[ARB_MAX_CH-1:NCH];
        end
    endgenerate

endmodule

// File: rtl/ext_bus_ctrl.sv
// External bus controller: arbitrates NCH requesters onto one multiplexed
// bus and sequences SETUP / STROBE / HOLD with programmable wait states.
// All pad strobes come from flops whose next value is derived from the
// next FSM state, so they line up exactly with the state they belong to.
module ext_bus_ctrl
    import ext_bus_pkg::*;
#(
    parameter int             AW       = 16,
    parameter int             DW       = 8,
    parameter int             NCH      = 2,
    parameter int             WW       = 3,
    parameter logic [AW-1:0]  CS_BASE  = AW'(CS_BASE_DFLT),
    parameter logic [AW-1:0]  CS_LIMIT = AW'(CS_LIMIT_DFLT)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    done,
    output logic [DW-1:0]     rdata,
    input  logic [WW-1:0]     wait_cfg,
    input  logic              test_hiz,
    output logic [AW-1:0]     ext_a,
    output logic              ext_a_oe,
    output logic [DW-1:0]     ext_d_out,
    input  logic [DW-1:0]     ext_d_in,
    output logic              ext_d_oe,
    output logic              ext_rd_n,
    output logic              ext_wr_n,
    output logic              ext_cs_n,
    output logic              busy
);

    ext_bus_state_t state_q, state_d;
    logic [NCH-1:0] ch_q, ch_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           we_q, we_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [WW-1:0]  wcnt_q, wcnt_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           cs_n_q, cs_n_d;
    logic           rd_n_q, rd_n_d;
    logic           wr_n_q, wr_n_d;
    logic           d_oe_q, d_oe_d;

    logic           arb_en;
    logic [NCH-1:0] arb_gnt;
    logic           start;
    logic [AW-1:0]  sel_addr;
    logic           sel_we;
    logic [DW-1:0]  sel_wdata;

    function automatic logic in_cs_window(input logic [AW-1:0] a);
        return (a >= CS_BASE) && (a <= CS_LIMIT);
    endfunction

    // New grants only from IDLE or HOLD, never in test mode or under reset.
    assign arb_en = nreset && !test_hiz && ((state_q == IDLE) || (state_q == HOLD));

    prio_arb #(
        .NCH (NCH)
    ) u_arb (
        .req (req),
        .en  (arb_en),
        .gnt (arb_gnt)
    );

    assign start = |arb_gnt;

    // Route the granted channel's address, direction and write data.
    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (arb_gnt[i]) begin
                sel_addr  = addr[i*AW +: AW];
                sel_we    = we[i];
                sel_wdata = wdata[i*DW +: DW];
            end
        end
    end

    // Bus cycle sequencing, transaction capture and read-data capture.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wcnt_d  = wcnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    ch_d    = arb_gnt;
                    addr_d  = sel_addr;
                    we_d    = sel_we;
                    wdata_d = sel_wdata;
                    wcnt_d  = wait_cfg;
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                if (wcnt_q == '0) begin
                    state_d = HOLD;
                    if (!we_q) begin
                        rdata_d = ext_d_in;
                    end
                end else begin
                    wcnt_d = wcnt_q - WW'(1);
                end
            end
            HOLD: begin
                // Back-to-back: regrant here and skip the IDLE bubble.
                if (start) begin
                    state_d = SETUP;
                    ch_d    = arb_gnt;
                    addr_d  = sel_addr;
                    we_d    = sel_we;
                    wdata_d = sel_wdata;
                    wcnt_d  = wait_cfg;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next pad strobe values, decoded from the state being entered.
    always_comb begin
        rd_n_d = !((state_d == STROBE) && !we_d);
        wr_n_d = !((state_d == STROBE) && we_d);
        d_oe_d = ((state_d == STROBE) || (state_d == HOLD)) && we_d;
        cs_n_d = !((state_d != IDLE) && in_cs_window(addr_d));
    end

    // State and pad registers; reset drives every strobe inactive at once.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wcnt_q  <= '0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            d_oe_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            d_oe_q  <= d_oe_d;
        end
    end

    assign gnt       = arb_gnt;
    assign done      = (state_q == HOLD) ? ch_q : '0;
    assign busy      = (state_q != IDLE);
    assign rdata     = rdata_q;
    assign ext_a     = addr_q;
    assign ext_d_out = wdata_q;

    // Test mode overrides the pads combinationally; sequencing carries on.
    assign ext_a_oe  = !test_hiz;
    assign ext_d_oe  = d_oe_q && !test_hiz;
    assign ext_rd_n  = rd_n_q || test_hiz;
    assign ext_wr_n  = wr_n_q || test_hiz;
    assign ext_cs_n  = cs_n_q || test_hiz;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Scoreboard bench for ext_bus_ctrl: stimulus pushes hand-computed
// expectations, a negedge monitor measures each bus cycle and pops on done.
module tb_ext_bus_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int NCH = 2;
    localparam int WW  = 3;

    typedef struct {
        int          ch;
        int          lat;
        int          cs;
        int          rd;
        int          wr;
        int          oe;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        bit          b2b;
    } exp_t;

    logic              clk;
    logic              nreset;
    logic [NCH-1:0]    req_r;
    logic [NCH-1:0]    we_r;
    logic [AW-1:0]     a_r [NCH];
    logic [DW-1:0]     wd_r [NCH];
    logic [NCH*AW-1:0] addr_bus;
    logic [NCH*DW-1:0] wdata_bus;
    logic [NCH-1:0]    gnt;
    logic [NCH-1:0]    done;
    logic [DW-1:0]     rdata;
    logic [WW-1:0]     wait_cfg;
    logic              test_hiz;
    logic [AW-1:0]     ext_a;
    logic              ext_a_oe;
    logic [DW-1:0]     ext_d_out;
    logic [DW-1:0]     ext_d_in;
    logic              ext_d_oe;
    logic              ext_rd_n;
    logic              ext_wr_n;
    logic              ext_cs_n;
    logic              busy;

    int n_check = 0;
    int n_pass  = 0;
    exp_t sb[$];

    assign addr_bus  = {a_r[1], a_r[0]};
    assign wdata_bus = {wd_r[1], wd_r[0]};

    ext_bus_ctrl #(
        .AW (AW), .DW (DW), .NCH (NCH), .WW (WW)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .req       (req_r),
        .we        (we_r),
        .addr      (addr_bus),
        .wdata     (wdata_bus),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .wait_cfg  (wait_cfg),
        .test_hiz  (test_hiz),
        .ext_a     (ext_a),
        .ext_a_oe  (ext_a_oe),
        .ext_d_out (ext_d_out),
        .ext_d_in  (ext_d_in),
        .ext_d_oe  (ext_d_oe),
        .ext_rd_n  (ext_rd_n),
        .ext_wr_n  (ext_wr_n),
        .ext_cs_n  (ext_cs_n),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push(input int ch, input int lat, input int cs, input int rd, input int wr,
                        input int oe, input logic [7:0] wd, input logic [7:0] rd_data, input bit b2b);
        exp_t e;
        e.ch = ch; e.lat = lat; e.cs = cs; e.rd = rd; e.wr = wr; e.oe = oe;
        e.wdata = wd; e.rdata = rd_data; e.b2b = b2b;
        sb.push_back(e);
    endtask

    task automatic setch(input int ch, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we_r[ch] = w;
        a_r[ch]  = a;
        wd_r[ch] = d;
    endtask

    // Raise the requests in mask and drop each one after its grant.
    task automatic request(input logic [NCH-1:0] mask, input int budget);
        logic [NCH-1:0] pend;
        logic [NCH-1:0] g;
        int n;
        pend  = mask;
        req_r = req_r | mask;
        n = 0;
        while (pend != '0 && n < budget) begin
            @(negedge clk);
            g = gnt & pend;
            @(posedge clk);
            #1;
            req_r = req_r & ~g;
            pend  = pend & ~g;
            n++;
        end
        if (pend != '0) begin
            check("grant_timeout", 32'(pend), 32'h0);
            req_r = req_r & ~pend;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("idle_timeout", 32'(sb.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: measure strobe widths per bus cycle, compare on done.
    int       cyc = 0;
    bit       active = 0;
    int       gnt_cyc, cs_cnt, rd_cnt, wr_cnt, oe_cnt;
    bit       b2b_seen;
    int       gnt_ch;
    logic [7:0] dout_seen;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!nreset) begin
            active = 0;
        end else begin
            if (active) begin
                if (!ext_cs_n) cs_cnt++;
                if (!ext_rd_n) rd_cnt++;
                if (!ext_wr_n) wr_cnt++;
                if (ext_d_oe) begin
                    oe_cnt++;
                    dout_seen = ext_d_out;
                end
            end
            if (done != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("done_onehot", 32'(done), 32'(1) << e.ch);
                    check("gnt_ch", 32'(gnt_ch), 32'(e.ch));
                    check("latency", 32'(cyc - gnt_cyc), 32'(e.lat));
                    check("cs_low_cycles", 32'(cs_cnt), 32'(e.cs));
                    check("rd_low_cycles", 32'(rd_cnt), 32'(e.rd));
                    check("wr_low_cycles", 32'(wr_cnt), 32'(e.wr));
                    check("d_oe_cycles", 32'(oe_cnt), 32'(e.oe));
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    check("back_to_back", 32'(b2b_seen), 32'(e.b2b));
                    if (e.oe > 0) check("d_out", 32'(dout_seen), 32'(e.wdata));
                end
                active = 0;
            end
            if (gnt != '0) begin
                active   = 1;
                gnt_cyc  = cyc;
                cs_cnt   = 0;
                rd_cnt   = 0;
                wr_cnt   = 0;
                oe_cnt   = 0;
                b2b_seen = (done != '0);
                gnt_ch   = 0;
                for (int i = 0; i < NCH; i++) if (gnt[i]) gnt_ch = i;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_g;
        bit seen_oe;
        bit seen_done;
        nreset   = 1'b0;
        test_hiz = 1'b0;
        req_r    = '0;
        we_r     = '0;
        wait_cfg = '0;
        ext_d_in = '0;
        for (int i = 0; i < NCH; i++) begin
            a_r[i]  = '0;
            wd_r[i] = '0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_ext_a", 32'(ext_a), 32'h0);
        check("rst_strobes", {29'h0, ext_rd_n, ext_wr_n, ext_cs_n}, 32'h7);
        check("rst_d_oe", 32'(ext_d_oe), 32'h0);
        check("rst_d_out", 32'(ext_d_out), 32'h0);
        check("rst_a_oe", 32'(ext_a_oe), 32'h1);
        @(posedge clk);
        #1 nreset = 1'b1;
        @(posedge clk);
        #1;

        // Single read, no wait states
        wait_cfg = 3'd0;
        ext_d_in = 8'h5A;
        setch(1, 1'b0, 16'hA000, 8'h00);
        push(1, 3, 3, 1, 0, 0, 8'h00, 8'h5A, 0);
        request(2'b10, 20);
        wait_idle(40);

        // Write with three wait states, outside the CS window
        wait_cfg = 3'd3;
        ext_d_in = 8'h00;
        setch(0, 1'b1, 16'h8000, 8'hC3);
        push(0, 6, 0, 0, 4, 5, 8'hC3, 8'h5A, 0);
        request(2'b01, 20);
        wait_idle(40);

        // Contention: ch0 first, ch1 regranted in ch0's HOLD
        wait_cfg = 3'd0;
        ext_d_in = 8'h77;
        setch(0, 1'b1, 16'hA100, 8'h11);
        setch(1, 1'b0, 16'hB000, 8'h00);
        push(0, 3, 3, 0, 1, 2, 8'h11, 8'h5A, 0);
        push(1, 3, 3, 1, 0, 0, 8'h00, 8'h77, 1);
        request(2'b11, 20);
        wait_idle(40);

        // CS window boundaries
        ext_d_in = 8'h01; setch(0, 1'b0, 16'h9FFF, 8'h00);
        push(0, 3, 0, 1, 0, 0, 8'h00, 8'h01, 0);
        request(2'b01, 20); wait_idle(40);
        ext_d_in = 8'h02; setch(0, 1'b0, 16'hA000, 8'h00);
        push(0, 3, 3, 1, 0, 0, 8'h00, 8'h02, 0);
        request(2'b01, 20); wait_idle(40);
        ext_d_in = 8'h03; setch(0, 1'b0, 16'hFDFF, 8'h00);
        push(0, 3, 3, 1, 0, 0, 8'h00, 8'h03, 0);
        request(2'b01, 20); wait_idle(40);
        ext_d_in = 8'h04; setch(0, 1'b0, 16'hFE00, 8'h00);
        push(0, 3, 0, 1, 0, 0, 8'h00, 8'h04, 0);
        request(2'b01, 20); wait_idle(40);

        // Maximum wait states
        wait_cfg = 3'd7;
        ext_d_in = 8'hE7;
        setch(1, 1'b0, 16'hC000, 8'h00);
        push(1, 10, 10, 8, 0, 0, 8'h00, 8'hE7, 0);
        request(2'b10, 20);
        wait_idle(60);

        // Reset in the middle of STROBE
        wait_cfg = 3'd3;
        ext_d_in = 8'h99;
        setch(0, 1'b0, 16'hC000, 8'h00);
        request(2'b01, 20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!ext_rd_n) break;
        end
        check("mid_strobe_rd_low", 32'(ext_rd_n), 32'h0);
        #2 nreset = 1'b0;
        #1;
        check("async_rst_strobes", {29'h0, ext_rd_n, ext_wr_n, ext_cs_n}, 32'h7);
        check("async_rst_busy", 32'(busy), 32'h0);
        seen_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done != '0) seen_done = 1;
        end
        check("rst_no_done", 32'(seen_done), 32'h0);
        check("rst_rdata_cleared", 32'(rdata), 32'h0);
        @(posedge clk);
        #1 nreset = 1'b1;
        @(posedge clk);
        #1;

        // Test high-Z: no grants, output enables low
        test_hiz = 1'b1;
        req_r[0] = 1'b1;
        seen_g = 0;
        seen_oe = 0;
        repeat (5) begin
            @(negedge clk);
            if (gnt != '0) seen_g = 1;
            if (ext_a_oe || ext_d_oe) seen_oe = 1;
        end
        check("hiz_no_gnt", 32'(seen_g), 32'h0);
        check("hiz_oe_low", 32'(seen_oe), 32'h0);
        check("hiz_strobes", {29'h0, ext_rd_n, ext_wr_n, ext_cs_n}, 32'h7);
        @(posedge clk);
        #1;
        req_r[0] = 1'b0;
        test_hiz = 1'b0;
        @(posedge clk);
        #1;

        // Recovery: write after reset leaves rdata at its reset value
        wait_cfg = 3'd1;
        setch(1, 1'b1, 16'hFDFF, 8'hAA);
        push(1, 4, 4, 0, 2, 3, 8'hAA, 8'h00, 0);
        request(2'b10, 20);
        wait_idle(40);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
